jt5205_ctrl: RTL and testbench

JT5205_CTRL -- requirements
Module: jt5205_ctrl

---
 rtl/jt5205_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_jt5205_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt5205_ctrl.sv
// ---------------------------------------------------------------------------
// jt5205_ctrl -- ROM-fed playback controller for a JT5205 ADPCM decoder.
//
// Reads a block of ADPCM bytes from start_addr up to and including end_addr.
// Each byte becomes two 4-bit nibbles on din. One nibble is used per vclk
// strobe. vclk comes from the decoder's own sample divider (its irq output).
// One byte is prefetched so that a slow ROM can hide its latency. When the
// ROM cannot keep up, the current nibble is held and a sticky underrun flag
// is raised.
//
// Parameters
//   AW        ROM byte-address width.
//   LO_FIRST  0: high nibble plays first, 1: low nibble plays first.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   vclk                  one-cycle sample strobe from the decoder
//   start, stop           one-cycle control pulses (stop has priority)
//   start_addr, end_addr  inclusive byte range, sampled on start
//   rom_addr, rom_cs      ROM request; address is held until rom_ok
//   rom_data, rom_ok      ROM response, valid only while rom_cs is high
//   din                   nibble to the decoder
//   dec_rst               holds the decoder in reset outside playback
//   busy                  a playback is in progress (priming or playing)
//   done                  one-cycle pulse after the last nibble was consumed
//   underrun              sticky: a vclk found no byte ready; cleared on start
// ---------------------------------------------------------------------------
module jt5205_ctrl #(
  parameter int AW       = 16,
  parameter bit LO_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vclk,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    din,
  output logic          dec_rst,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] end_q;      // last byte address of the running sample
  logic [7:0]    cur;        // byte being played
  logic [7:0]    nxt;        // prefetched byte
  logic          nxt_valid;
  logic          more;       // bytes remain to fetch beyond cur/nxt
  logic          phase;      // 0: first nibble of cur on din, 1: second

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return LO_FIRST ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return LO_FIRST ? b[7:4] : b[3:0];
  endfunction

  assign busy    = (state != ST_IDLE);
  assign dec_rst = (state != ST_PLAY);

  // NOTE: every register below uses non-blocking assignments, so all of them
  // update together at the clock edge. Blocking assignments here would let
  // later statements see half-updated state, and simulation and synthesis
  // could then disagree.
  // NOTE: cur and nxt are plain registers and not a RAM. That makes them
  // cheap to reset, so the data path also comes out of reset in a known
  // state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      end_q     <= '0;
      cur       <= '0;
      nxt       <= '0;
      nxt_valid <= 1'b0;
      more      <= 1'b0;
      phase     <= 1'b0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      din       <= '0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort. Any ROM response still in flight arrives with rom_cs low
        // and is therefore ignored.
        state     <= ST_IDLE;
        rom_cs    <= 1'b0;
        nxt_valid <= 1'b0;
        more      <= 1'b0;
      end else if (start) begin
        // A start while busy behaves like an abort plus a fresh start.
        // rom_cs drops for one cycle, so a response to the old address
        // cannot be taken as data for the new one.
        underrun  <= 1'b0;
        end_q     <= end_addr;
        rom_addr  <= start_addr;
        rom_cs    <= 1'b0;
        nxt_valid <= 1'b0;
        more      <= 1'b0;
        phase     <= 1'b0;
        if (start_addr > end_addr) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else begin
          state <= ST_PRIME;
        end
      end else begin
        case (state)
          ST_PRIME: begin
            if (rom_cs && rom_ok) begin
              cur      <= rom_data;
              din      <= first_nib(rom_data);
              rom_addr <= rom_addr + AW'(1);
              rom_cs   <= 1'b0;
              // Compare before the increment so that end_addr = all-ones
              // never issues a fetch at the wrapped address.
              more     <= (rom_addr != end_q);
              phase    <= 1'b0;
              state    <= ST_PLAY;
            end else begin
              rom_cs <= 1'b1;
            end
          end

          ST_PLAY: begin
            // Prefetch. A request is only raised when nxt is empty. Capture
            // clears rom_cs, so it stays low for at least one cycle.
            if (rom_cs) begin
              if (rom_ok) begin
                nxt       <= rom_data;
                nxt_valid <= 1'b1;
                rom_addr  <= rom_addr + AW'(1);
                rom_cs    <= 1'b0;
                more      <= (rom_addr != end_q);
              end
            end else if (!nxt_valid && more) begin
              rom_cs <= 1'b1;
            end

            // Nibble consumption. The ROM capture needs nxt empty, and the
            // byte swap needs nxt full, so the two never act in the same
            // cycle.
            if (vclk) begin
              if (!phase) begin
                din   <= second_nib(cur);
                phase <= 1'b1;
              end else if (nxt_valid) begin
                cur       <= nxt;
                nxt_valid <= 1'b0;
                din       <= first_nib(nxt);
                phase     <= 1'b0;
              end else if (!more) begin
                // cur was the byte at end_addr, and both of its nibbles
                // have now been consumed.
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                // The ROM is too slow. Hold din and phase, and let the next
                // vclk try again.
                underrun <= 1'b1;
              end
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt5205_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jt5205_ctrl -- self-checking bench for jt5205_ctrl.
// Two instances (LO_FIRST=0 and LO_FIRST=1) receive the same stimulus. Each
// has its own ROM responder with a programmable latency. A monitor records
// the nibble stream each instance presents to its decoder. Playback
// scenarios come from a table; abort, restart and reset cases are written
// out by hand.
// ---------------------------------------------------------------------------
module tb_jt5205_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vclk = 1'b0;
  logic        start, stop;
  logic [15:0] start_addr, end_addr;

  logic [15:0] rom_addr [2];
  logic        rom_cs   [2];
  logic [7:0]  rom_data [2];
  logic        rom_ok   [2];
  logic [3:0]  din      [2];
  logic        dec_rst  [2];
  logic        busy     [2];
  logic        done     [2];
  logic        underrun [2];

  // ROM model state
  logic [7:0]  mem [65536];
  int          lat;
  int          cnt    [2] = '{0, 0};
  logic        m_ok   [2] = '{1'b0, 1'b0};
  logic [7:0]  m_data [2] = '{8'h00, 8'h00};
  logic        extra_ok;
  logic [7:0]  extra_data;

  // vclk generator
  logic ven;
  int   vper;
  int   vc = 0;

  // monitor state
  logic [3:0] cap [2][256];
  int   cap_n     [2] = '{0, 0};
  int   done_cnt  [2] = '{0, 0};
  int   done_vclk [2] = '{0, 0};
  int   vplay     [2] = '{0, 0};
  int   cs_cnt    [2] = '{0, 0};
  logic prev_dr   [2] = '{1'b1, 1'b1};
  logic [3:0] prev_din [2] = '{4'h0, 4'h0};
  logic wrap_bad = 1'b0;

  // snapshots taken at each start
  int cb [2], db [2], dvb [2], vb [2], csb [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jt5205_ctrl #(.AW(16), .LO_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .vclk(vclk), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr[0]), .rom_cs(rom_cs[0]), .rom_data(rom_data[0]),
    .rom_ok(rom_ok[0]), .din(din[0]), .dec_rst(dec_rst[0]), .busy(busy[0]),
    .done(done[0]), .underrun(underrun[0])
  );

  jt5205_ctrl #(.AW(16), .LO_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .vclk(vclk), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr[1]), .rom_cs(rom_cs[1]), .rom_data(rom_data[1]),
    .rom_ok(rom_ok[1]), .din(din[1]), .dec_rst(dec_rst[1]), .busy(busy[1]),
    .done(done[1]), .underrun(underrun[1])
  );

  assign rom_ok[0]   = m_ok[0] | extra_ok;
  assign rom_ok[1]   = m_ok[1] | extra_ok;
  assign rom_data[0] = extra_ok ? extra_data : m_data[0];
  assign rom_data[1] = extra_ok ? extra_data : m_data[1];

  // ROM responder: rom_ok rises 'lat' cycles after rom_cs and lasts one
  // cycle. It resets whenever rom_cs is low.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rom_cs[g] && !m_ok[g]) begin
        cnt[g] = cnt[g] + 1;
        if (cnt[g] >= lat) begin
          m_ok[g]   = 1'b1;
          m_data[g] = mem[rom_addr[g]];
          cnt[g]    = 0;
        end
      end else begin
        m_ok[g] = 1'b0;
        cnt[g]  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (ven) begin
      if (vc >= vper - 1) begin
        vclk = 1'b1;
        vc   = 0;
      end else begin
        vclk = 1'b0;
        vc   = vc + 1;
      end
    end else begin
      vclk = 1'b0;
      vc   = 0;
    end
  end

  // Monitor, sampled 1 time unit after the rising edge. vclk still holds
  // the value the DUT sampled at that edge.
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (vclk && !prev_dr[g]) vplay[g] = vplay[g] + 1;
      if (done[g]) begin
        done_cnt[g] = done_cnt[g] + 1;
        if (vclk && !prev_dr[g]) done_vclk[g] = done_vclk[g] + 1;
      end
      if (!dec_rst[g] && (prev_dr[g] || din[g] != prev_din[g]) && cap_n[g] < 256) begin
        cap[g][cap_n[g]] = din[g];
        cap_n[g] = cap_n[g] + 1;
      end
      if (rom_cs[g]) cs_cnt[g] = cs_cnt[g] + 1;
      if (rom_cs[g] && rom_addr[g] == 16'h0000) wrap_bad = 1'b1;
      prev_dr[g]  = dec_rst[g];
      prev_din[g] = din[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    for (int g = 0; g < 2; g++) begin
      cb[g]  = cap_n[g];
      db[g]  = done_cnt[g];
      dvb[g] = done_vclk[g];
      vb[g]  = vplay[g];
      csb[g] = cs_cnt[g];
    end
  endtask

  // Pulse start for one cycle and take snapshots at the same negedge.
  task automatic pulse_start(input logic [15:0] sa, input logic [15:0] ea, input logic with_stop);
    @(negedge clk);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    stop       = with_stop;
    snap();
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Wait for done on both instances, then compare what was played.
  task automatic play_check(input string tag, input int n, input logic [31:0] e0,
                            input logic [31:0] e1, input logic under, input logic chk_vcnt);
    logic [31:0] got;
    int k;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_cnt[0] > db[0] && done_cnt[1] > db[1]) break;
    end
    check($sformatf("%s_done_seen", tag), (done_cnt[0] > db[0]) && (done_cnt[1] > db[1]), 1);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      got = '0;
      k = cap_n[g] - cb[g];
      for (int i = 0; i < k && i < 8; i++) got[31-4*i -: 4] = cap[g][cb[g]+i];
      check($sformatf("%s_d%0d_nibble_count", tag, g), k, n);
      check($sformatf("%s_d%0d_nibbles", tag, g), got, (g == 0) ? e0 : e1);
      check($sformatf("%s_d%0d_done_pulses", tag, g), done_cnt[g] - db[g], 1);
      check($sformatf("%s_d%0d_done_after_vclk", tag, g), done_vclk[g] - dvb[g], 1);
      if (chk_vcnt) check($sformatf("%s_d%0d_vclks_to_done", tag, g), vplay[g] - vb[g], n);
      check($sformatf("%s_d%0d_underrun", tag, g), underrun[g], under);
      check($sformatf("%s_d%0d_busy_after", tag, g), busy[g], 0);
      check($sformatf("%s_d%0d_dec_rst_after", tag, g), dec_rst[g], 1);
    end
  endtask

  typedef struct {
    logic [15:0] sa;
    logic [15:0] ea;
    int          lat;
    int          vper;
    int          n;
    logic [31:0] exp0;   // nibble stream for LO_FIRST=0, first nibble in MSBs
    logic [31:0] exp1;   // nibble stream for LO_FIRST=1
    logic        under;
  } scen_t;

  scen_t tbl [4];

  initial begin
    tbl[0] = '{16'h0010, 16'h0011,   2, 64, 4, 32'h3AC5_0000, 32'hA35C_0000, 1'b0};
    tbl[1] = '{16'h0030, 16'h0032,   3, 16, 6, 32'h5A69_B400, 32'hA596_4B00, 1'b0};
    tbl[2] = '{16'h0040, 16'h0042, 200, 64, 6, 32'h1234_5600, 32'h2143_6500, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF,   2, 32, 2, 32'h9E00_0000, 32'hE900_0000, 1'b0};

    mem[16'h0000] = 8'h77;
    mem[16'h0010] = 8'h3A; mem[16'h0011] = 8'hC5;
    mem[16'h0030] = 8'h5A; mem[16'h0031] = 8'h69; mem[16'h0032] = 8'hB4;
    mem[16'h0040] = 8'h12; mem[16'h0041] = 8'h34; mem[16'h0042] = 8'h56;
    mem[16'hFFFF] = 8'h9E;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    start_addr = '0; end_addr = '0;
    extra_ok = 1'b0; extra_data = 8'h00;
    ven = 1'b0; vper = 64; lat = 2;

    // Reset state
    #12;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_d%0d_dec_rst", g), dec_rst[g], 1);
      check($sformatf("rst_d%0d_busy", g), busy[g], 0);
      check($sformatf("rst_d%0d_rom_cs", g), rom_cs[g], 0);
      check($sformatf("rst_d%0d_done", g), done[g], 0);
      check($sformatf("rst_d%0d_underrun", g), underrun[g], 0);
      check($sformatf("rst_d%0d_din", g), din[g], 0);
      check($sformatf("rst_d%0d_rom_addr", g), rom_addr[g], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven playback scenarios
    for (int s = 0; s < 4; s++) begin
      lat  = tbl[s].lat;
      vper = tbl[s].vper;
      ven  = 1'b1;
      pulse_start(tbl[s].sa, tbl[s].ea, 1'b0);
      for (int g = 0; g < 2; g++)
        check($sformatf("scen%0d_d%0d_underrun_cleared", s, g), underrun[g], 0);
      play_check($sformatf("scen%0d", s), tbl[s].n, tbl[s].exp0, tbl[s].exp1,
                 tbl[s].under, !tbl[s].under);
      ven = 1'b0;
    end

    // start_addr > end_addr: a done pulse, no fetch, stay idle
    pulse_start(16'h0020, 16'h001F, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("empty_d%0d_done", g), done[g], 1);
      check($sformatf("empty_d%0d_busy", g), busy[g], 0);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("empty_d%0d_done_width", g), done[g], 0);
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("empty_d%0d_no_rom_cs", g), cs_cnt[g] - csb[g], 0);

    // start and stop together: stop wins
    pulse_start(16'h0010, 16'h0011, 1'b1);
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("startstop_d%0d_busy", g), busy[g], 0);
      check($sformatf("startstop_d%0d_no_rom_cs", g), cs_cnt[g] - csb[g], 0);
      check($sformatf("startstop_d%0d_no_done", g), done_cnt[g] - db[g], 0);
    end

    // stop during the priming fetch; a late rom_ok is ignored
    lat = 20;
    pulse_start(16'h0010, 16'h0011, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (rom_cs[0]) break;
      @(negedge clk);
    end
    check("stop_rom_cs_raised", rom_cs[0], 1);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stop_d%0d_rom_cs", g), rom_cs[g], 0);
      check($sformatf("stop_d%0d_dec_rst", g), dec_rst[g], 1);
      check($sformatf("stop_d%0d_busy", g), busy[g], 0);
    end
    extra_data = 8'hEE;
    extra_ok   = 1'b1;
    @(negedge clk);
    extra_ok   = 1'b0;
    repeat (40) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stop_d%0d_no_done", g), done_cnt[g] - db[g], 0);
      check($sformatf("stop_d%0d_nothing_played", g), cap_n[g] - cb[g], 0);
      check($sformatf("stop_d%0d_din_held", g), din[g], (g == 0) ? 4'hE : 4'h9);
      check($sformatf("stop_d%0d_idle_cs", g), rom_cs[g], 0);
    end

    // start while busy: restart with new addresses
    lat  = 200;
    vper = 64;
    ven  = 1'b1;
    pulse_start(16'h0040, 16'h0042, 1'b0);
    repeat (20) @(negedge clk);
    lat = 2;
    pulse_start(16'h0010, 16'h0011, 1'b0);
    play_check("restart", 4, 32'h3AC5_0000, 32'hA35C_0000, 1'b0, 1'b1);
    ven = 1'b0;

    // Asynchronous reset during a ROM access
    lat = 50;
    pulse_start(16'h0030, 16'h0032, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (rom_cs[0]) break;
      @(negedge clk);
    end
    check("areset_rom_cs_raised", rom_cs[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("areset_d%0d_rom_cs", g), rom_cs[g], 0);
      check($sformatf("areset_d%0d_dec_rst", g), dec_rst[g], 1);
      check($sformatf("areset_d%0d_rom_addr", g), rom_addr[g], 0);
      check($sformatf("areset_d%0d_din", g), din[g], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("no_wrap_fetch_at_0000", wrap_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
